// File: rtl/alu_vec_pkg.sv
// Shared opcode encoding for the vector ALU pipeline and its lanes.
package alu_vec_pkg;

    localparam int OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_MUL    = 4'd2,
        OP_AND    = 4'd3,
        OP_OR     = 4'd4,
        OP_XOR    = 4'd5,
        OP_NOT    = 4'd6,
        OP_SHL    = 4'd7,
        OP_SHR    = 4'd8,
        OP_MAC    = 4'd9,
        OP_CLRACC = 4'd10
    } opcode_e;

endpackage

// File: rtl/alu_vec_pipe_lane.sv
// One ALU lane: combinational datapath on the S1 operands plus the lane's
// multiply-accumulate register, which updates when the transaction enters S2.
module alu_lane
    import alu_vec_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_mask,
    input  opcode_e            i_op,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_result,
    output logic               o_gt,
    output logic               o_eq,
    output logic               o_lt,
    output logic               o_ovf
);

    localparam int SHW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_raw;
    logic [2*WIDTH:0]   w_mac;
    logic [SHW-1:0]     w_sh;
    logic [2*WIDTH-1:0] r_acc;

    assign w_a_ext = {{WIDTH{1'b0}}, i_a};
    assign w_b_ext = {{WIDTH{1'b0}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;
    assign w_mac   = {1'b0, r_acc} + {1'b0, w_prod};
    assign w_sh    = i_b[SHW-1:0];

    always_comb begin
        w_raw = '0;
        case (i_op)
            OP_ADD: w_raw = w_a_ext + w_b_ext;
            OP_SUB: w_raw = w_a_ext - w_b_ext;
            OP_MUL: w_raw = w_prod;
            OP_AND: w_raw = w_a_ext & w_b_ext;
            OP_OR:  w_raw = w_a_ext | w_b_ext;
            OP_XOR: w_raw = w_a_ext ^ w_b_ext;
            OP_NOT: w_raw = {{WIDTH{1'b0}}, ~i_a};
            OP_SHL: w_raw = w_a_ext << w_sh;
            OP_SHR: w_raw = w_a_ext >> w_sh;
            OP_MAC: w_raw = w_mac[2*WIDTH-1:0];
            default: w_raw = '0;
        endcase
    end

    assign o_result = i_mask ? w_raw : '0;
    assign o_gt     = i_mask && (i_a > i_b);
    assign o_eq     = i_mask && (i_a == i_b);
    assign o_lt     = i_mask && (i_a < i_b);
    assign o_ovf    = i_mask && (i_op == OP_MAC) && w_mac[2*WIDTH];

    // i_load is high for exactly one edge per transaction, so stalls never re-apply a MAC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_load && i_mask) begin
            if (i_op == OP_MAC) begin
                r_acc <= w_mac[2*WIDTH-1:0];
            end else if (i_op == OP_CLRACC) begin
                r_acc <= '0;
            end
        end
    end

endmodule

// File: rtl/alu_vec_pipe.sv
// Two-stage vector ALU with valid/ready flow control: S1 holds operands,
// S2 holds per-lane results and flags. Lane datapaths live in alu_lane.
module alu_vec_pipe
    import alu_vec_pkg::*;
#(
    parameter int LANES = 4,
    parameter int WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [LANES-1:0][WIDTH-1:0]       in_a,
    input  logic [LANES-1:0][WIDTH-1:0]       in_b,
    input  logic [OPCODE_W-1:0]               in_opcode,
    input  logic [LANES-1:0]                  in_lane_mask,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [LANES-1:0][2*WIDTH-1:0]     out_result,
    output logic [LANES-1:0]                  out_gt,
    output logic [LANES-1:0]                  out_eq,
    output logic [LANES-1:0]                  out_lt,
    output logic [LANES-1:0]                  out_acc_ovf
);

    logic                          r_s1_valid;
    logic [LANES-1:0][WIDTH-1:0]   r_s1_a;
    logic [LANES-1:0][WIDTH-1:0]   r_s1_b;
    opcode_e                       r_s1_op;
    logic [LANES-1:0]              r_s1_mask;

    logic                          r_s2_valid;
    logic [LANES-1:0][2*WIDTH-1:0] r_s2_result;
    logic [LANES-1:0]              r_s2_gt;
    logic [LANES-1:0]              r_s2_eq;
    logic [LANES-1:0]              r_s2_lt;
    logic [LANES-1:0]              r_s2_ovf;

    logic                          w_stall;
    logic                          w_load;
    logic [LANES-1:0][2*WIDTH-1:0] w_result;
    logic [LANES-1:0]              w_gt;
    logic [LANES-1:0]              w_eq;
    logic [LANES-1:0]              w_lt;
    logic [LANES-1:0]              w_ovf;

    assign w_stall  = r_s2_valid && !out_ready;
    assign in_ready = !r_s1_valid || !w_stall;
    assign w_load   = r_s1_valid && !w_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= OP_ADD;
            r_s1_mask  <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a    <= in_a;
                r_s1_b    <= in_b;
                r_s1_op   <= opcode_e'(in_opcode);
                r_s1_mask <= in_lane_mask;
            end
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        alu_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_load   (w_load),
            .i_mask   (r_s1_mask[gi]),
            .i_op     (r_s1_op),
            .i_a      (r_s1_a[gi]),
            .i_b      (r_s1_b[gi]),
            .o_result (w_result[gi]),
            .o_gt     (w_gt[gi]),
            .o_eq     (w_eq[gi]),
            .o_lt     (w_lt[gi]),
            .o_ovf    (w_ovf[gi])
        );
    end

    // Outputs only change when not stalled, which keeps them stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_gt     <= '0;
            r_s2_eq     <= '0;
            r_s2_lt     <= '0;
            r_s2_ovf    <= '0;
        end else if (!w_stall) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_result <= w_result;
                r_s2_gt     <= w_gt;
                r_s2_eq     <= w_eq;
                r_s2_lt     <= w_lt;
                r_s2_ovf    <= w_ovf;
            end
        end
    end

    assign out_valid   = r_s2_valid;
    assign out_result  = r_s2_result;
    assign out_gt      = r_s2_gt;
    assign out_eq      = r_s2_eq;
    assign out_lt      = r_s2_lt;
    assign out_acc_ovf = r_s2_ovf;

endmodule

// File: doc/alu_vec_pipe.md
# alu_vec_pipe

Pipelined, parametrised vector ALU: `LANES` independent unsigned lanes share one opcode per transaction. Each lane produces a double-width result and comparison flags. It is the registered, flow-controlled successor to the combinational ALU array. It adds a valid/ready handshake with backpressure, a per-lane enable mask, and per-lane multiply-accumulate state. It sits between the operand-fetch stage and the result writeback buffer.

## Interface
- `LANES`, 4, number of lanes (≥1)
- `WIDTH`, 8, operand width in bits (≥2); results are `2*WIDTH`
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  transaction offered
- `in_ready`  out  1  block can accept a transaction this cycle
- `in_a`, `in_b`  in  `[LANES][WIDTH]`  per-lane operands
- `in_opcode`  in  4  operation, shared by all lanes
- `in_lane_mask`  in  `LANES`  1 = lane active
- `out_valid`  out  1  result held on outputs
- `out_ready`  in  1  downstream accepts the result
- `out_result`  out  `[LANES][2*WIDTH]`  per-lane result
- `out_gt`, `out_eq`, `out_lt`  out  `LANES`  unsigned compare of `a` vs `b`
- `out_acc_ovf`  out  `LANES`  carry out of that transaction's MAC add

## Operation
- Opcodes (all unsigned; results are `2*WIDTH` wide and wrap modulo 2^(2W)):
  - 0 ADD: `a+b`
  - 1 SUB: zero-extended `a-b`
  - 2 MUL: `a*b`
  - 3 AND, 4 OR, 5 XOR: zero-extended bitwise results
  - 6 NOT: zero-extended `~a`
  - 7 SHL: `a << b[$clog2(WIDTH)-1:0]`, computed at `2*WIDTH`
  - 8 SHR: `a >> b[$clog2(WIDTH)-1:0]`
  - 9 MAC: `acc += a*b`; result is the new `acc`
  - 10 CLRACC: `acc = 0`; result is 0
  - 11–15 reserved: result 0; `acc` unchanged
- Per-lane accumulator `acc`, `2*WIDTH` bits. It is modified only by MAC and CLRACC, in active lanes only.
- `out_acc_ovf[i]`: carry out of the MAC addition. It is 0 for every non-MAC opcode.
- Masked lane (mask bit 0):
  - result, flags and `out_acc_ovf` are 0
  - `acc` is untouched
  - the lane still occupies its slot in the transaction
- Compare flags are valid for all active lanes regardless of opcode. Exactly one of gt/eq/lt is set.
- Two-stage pipeline:
  - S1 registers operands, opcode and mask.
  - S2 computes and registers results and flags, and updates `acc`.

## Timing
- Accept on `in_valid && in_ready`. Transfer out on `out_valid && out_ready`.
- Latency: a transaction accepted at edge N is presented with `out_valid=1` after edge N+1. This is two cycles at full throughput, one transaction per cycle.
- `stall = out_valid && !out_ready`.
  - S1 advances into S2 when `!stall`.
  - `in_ready = !s1_valid || !stall`, so a bubble in S1 is always fillable. The path is combinational from `out_ready`.
- While stalled, all `out_*` signals hold stable.
- `acc` updates exactly once per transaction, on the edge it enters S2. Stalls never re-apply a MAC.
- Back-to-back MACs on a lane chain correctly: the second MAC sees the first one's updated `acc`.
- Upstream must hold `in_*` stable while `in_valid && !in_ready`. Dropping `in_valid` before acceptance is permitted.
- Reset (asynchronous, any time, including mid-stall):
  - S1/S2 valids clear, `out_valid=0`
  - `out_result`, flags and `out_acc_ovf` go to 0
  - all `acc` go to 0
  - `in_ready=1` from the first cycle after `rst_n` deasserts
  - in-flight transactions are discarded

## Structure
- Package `alu_vec_pkg`:
  - `opcode_e` enum (4-bit) with the values above
  - `OPCODE_W = 4`
- Sub-module `alu_lane #(WIDTH)` is instantiated `LANES` times by a generate loop. It contains the combinational datapath for one lane plus that lane's `acc` register and its update enable.
- Top level contains only the pipeline valids, the handshake logic and the S1/S2 registers.

## Test plan
- Reset then ADD with `WIDTH=8`, a=200, b=100, all lanes, `out_ready=1` → after 2 cycles result=300, gt=1, `out_acc_ovf=0`.
- SUB a=3, b=5 → result=16'hFFFE, lt=1. MUL a=255, b=255 → 65025. SHL a=8'h81, b=4 → 16'h0810.
- Three back-to-back MACs (2×3, 4×5, 1×1) on lane 0, then CLRACC → results 6, 26, 27, 0. Then MAC 1×1 → 1.
- Mask 4'b0101 with MAC 2×2 repeated twice → lanes 0/2 give 4 then 8; lanes 1/3 give 0 with flags 0. CLRACC unmasked, then MAC 1×1 → every lane gives 1.
- Backpressure: stream 5 MACs while `out_ready` toggles 1,0,0,1,… → outputs stable while stalled, no transaction lost or duplicated, final `acc` = exact sum of products.
- Assert `rst_n=0` while `out_valid=1` and stalled → `out_valid`, `out_result` and `acc` go to 0 immediately. Next MAC 1×1 → 1.
